// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with arbitrary depth (power of two not
// required), programmable almost-full / almost-empty thresholds and a choice
// of registered or first-word-fall-through read data.
//
// Build option: define SYNC_FIFO_PROG_ERR_FLAGS_EN to get sticky overflow /
// underflow flags. Without it the ports are still present and tied to 0.
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 10,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           wr_en,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           rd_en,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full,
  output logic                           almost_empty,
  output logic                           almost_full,
  output logic                           overflow,
  output logic                           underflow
);

  // Pointer width covers indices 0..DEPTH-1; count width covers 0..DEPTH.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_THRESH);

  // Illegal configurations stop elaboration instead of building a broken FIFO.
  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_prog: DEPTH must be >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
      $error("sync_fifo_prog: AF_THRESH must be within 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
      $error("sync_fifo_prog: AE_THRESH must be within 0..DEPTH-1");
    end
    if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
      $error("sync_fifo_prog: FWFT must be 0 or 1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_r;
  logic                  push;
  logic                  pop;

  // Pointers step by one and wrap explicitly at DEPTH-1, so any depth works.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Flags decode straight from the registered fill level.
  always_comb begin
    empty        = (count_r == '0);
    full         = (count_r == DEPTH_C);
    almost_full  = (count_r >= AF_C);
    almost_empty = (count_r <= AE_C);
  end

  // Accepted operations; flush suppresses both, and a full FIFO seeing
  // push+pop therefore performs only the pop (empty: only the push).
  always_comb begin
    push = wr_en & ~full  & ~flush;
    pop  = rd_en & ~empty & ~flush;
  end

  assign count = count_r;

  // Storage array carries data only, so it is written without reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Write/read pointers and fill level; flush returns them to the origin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Read data path: head word shown directly, or captured on each pop.
  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data = mem[rd_ptr];
    end else begin : g_reg_rd
      logic [DATA_WIDTH-1:0] rd_data_r;

      // Capture the head word on an accepted pop; hold through flush and idle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_r <= '0;
        end else if (pop) begin
          rd_data_r <= mem[rd_ptr];
        end
      end

      assign rd_data = rd_data_r;
    end
  endgenerate

`ifdef SYNC_FIFO_PROG_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags: a push into full with no pop to make room, or a pop
  // from empty; only reset or flush clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_en & full & ~pop) begin
        overflow_r <= 1'b1;
      end
      if (rd_en & empty) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a registered-read and a fall-through instance
// share one stimulus stream and are checked every cycle against a queue model.
module tb_sync_fifo_prog;

  localparam int DW    = 8;
  localparam int DEPTH = 10;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

`ifdef SYNC_FIFO_PROG_ERR_FLAGS_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;

  logic [DW-1:0] rd_data0, rd_data1;
  logic [CW-1:0] count0, count1;
  logic          empty0, full0, ae0, af0, ovf0, unf0;
  logic          empty1, full1, ae1, af1, ovf1, unf1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Behavioural model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd0;
  bit            m_ovf, m_unf;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data0), .count(count0), .empty(empty0),
    .full(full0), .almost_empty(ae0), .almost_full(af0),
    .overflow(ovf0), .underflow(unf0));

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data1), .count(count1), .empty(empty1),
    .full(full1), .almost_empty(ae1), .almost_full(af1),
    .overflow(ovf1), .underflow(unf1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Model: FIFO as a queue, updated from the operation rules at each edge.
  task automatic model_step();
    bit was_full, was_empty, do_pop, do_push;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    do_pop    = rd_en && !was_empty && !flush;
    do_push   = wr_en && !was_full && !flush;
    if (flush) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (wr_en && was_full && !do_pop) m_ovf = 1;
      if (rd_en && was_empty)           m_unf = 1;
      if (do_pop)  m_rd0 = q.pop_front();
      if (do_push) q.push_back(wr_data);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_rd0 = '0;
      m_ovf = 0;
      m_unf = 0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = q.size();
      chk("count0", int'(count0), n);
      chk("count1", int'(count1), n);
      chk("empty0", int'(empty0), int'(n == 0));
      chk("full0",  int'(full0),  int'(n == DEPTH));
      chk("aempty0", int'(ae0),   int'(n <= AE));
      chk("afull0", int'(af0),    int'(n >= AF));
      chk("empty1", int'(empty1), int'(n == 0));
      chk("full1",  int'(full1),  int'(n == DEPTH));
      chk("ovf0",   int'(ovf0),   ERR_EN ? int'(m_ovf) : 0);
      chk("unf0",   int'(unf0),   ERR_EN ? int'(m_unf) : 0);
      chk("ovf1",   int'(ovf1),   ERR_EN ? int'(m_ovf) : 0);
      chk("rd_data0", int'(rd_data0), int'(m_rd0));
      if (n > 0) chk("rd_data1", int'(rd_data1), int'(q[0]));
    end
  end

  // Drive one cycle of inputs, let the edge take them, settle 1 time unit.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    flush   = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, '0, 0, 0);
  endtask

  initial begin
    int pushed, popped, pw, pr;
    rst = 1'b1; flush = 0; wr_en = 0; rd_en = 0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1;

    // Reset state
    chk("rst_count", int'(count0), 0);
    chk("rst_empty", int'(empty0), 1);
    chk("rst_full",  int'(full0),  0);
    chk("rst_ae",    int'(ae0),    1);
    chk("rst_af",    int'(af0),    0);
    chk("rst_rd",    int'(rd_data0), 0);

    // Fill 0x01..0x0A
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, DW'(i), 0, 0);
      if (i == 7)  chk("fill_af_at7",  int'(af0), 0);
      if (i == 8)  chk("fill_af_at8",  int'(af0), 1);
      if (i == 9)  chk("fill_full_at9", int'(full0), 0);
    end
    chk("fill_count10", int'(count0), 10);
    chk("fill_full",    int'(full0), 1);
    step(1, 8'hFF, 0, 0);
    chk("fill_drop_count", int'(count0), 10);
    chk("fill_overflow",   int'(ovf0), ERR_EN);
    chk("fill_fwft_head",  int'(rd_data1), 8'h01);

    // Push+pop while full: pop only
    step(1, 8'h0B, 1, 0);
    chk("pp_full_count", int'(count0), 9);
    chk("pp_full_rd",    int'(rd_data0), 8'h01);
    repeat (4) step(0, '0, 1, 0);
    chk("pop_count5", int'(count0), 5);
    chk("pop_rd5",    int'(rd_data0), 8'h05);

    // Push+pop at count 5
    step(1, 8'h0C, 1, 0);
    chk("pp5_count", int'(count0), 5);
    chk("pp5_rd",    int'(rd_data0), 8'h06);

    // Flush at count 7 with a write pending
    step(1, 8'h0D, 0, 0);
    step(1, 8'h0E, 0, 0);
    chk("pre_flush_count", int'(count0), 7);
    step(1, 8'h77, 0, 1);
    chk("flush_count", int'(count0), 0);
    chk("flush_empty", int'(empty0), 1);
    chk("flush_ovf",   int'(ovf0), 0);
    chk("flush_rd_hold", int'(rd_data0), 8'h06);
    idle();
    chk("flush_write_dropped", int'(count0), 0);

    // Push+pop while empty: push only
    step(1, 8'h42, 1, 0);
    chk("pp0_count", int'(count0), 1);
    chk("pp0_rd_hold", int'(rd_data0), 8'h06);
    chk("pp0_underflow", int'(unf0), ERR_EN);
    chk("pp0_fwft", int'(rd_data1), 8'h42);
    step(0, '0, 0, 1);
    chk("flush2_unf", int'(unf0), 0);

    // Fall-through: pushed word visible next cycle without rd_en
    step(1, 8'h55, 0, 0);
    chk("fwft_empty", int'(empty1), 0);
    chk("fwft_rd",    int'(rd_data1), 8'h55);
    step(0, '0, 1, 0);
    chk("fwft_pop_rd0", int'(rd_data0), 8'h55);

    // Stream 25 words across pointer wrap, pops interleaved with pushes
    step(0, '0, 0, 1);
    pushed = 0;
    popped = 0;
    while (popped < 25) begin
      bit w, r;
      w = (pushed < 25);
      r = ((pushed - popped) >= 3) || (!w && (pushed > popped));
      step(w, DW'(8'h20 + pushed), r, 0);
      if (w) pushed++;
      if (r) begin
        popped++;
        chk("stream_order", int'(rd_data0), 8'h20 + popped - 1);
      end
    end

    // Async reset mid-stream, between clock edges
    for (int i = 0; i < 6; i++) step(1, DW'(8'h90 + i), 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", int'(count0), 0);
    chk("arst_empty", int'(empty0), 1);
    chk("arst_ae",    int'(ae0), 1);
    chk("arst_rd",    int'(rd_data0), 0);
    chk("arst_count1", int'(count1), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 8'hA5, 0, 0);
    chk("arst_fwft_rd", int'(rd_data1), 8'hA5);
    step(0, '0, 1, 0);
    chk("arst_readback", int'(rd_data0), 8'hA5);

    // Randomised traffic with shifting push/pop bias and occasional flush
    for (int e = 0; e < 16; e++) begin
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int c = 0; c < 200; c++) begin
        step($urandom_range(0, 99) < pw, DW'($urandom), $urandom_range(0, 99) < pr,
             $urandom_range(0, 63) == 0);
      end
    end
    idle();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
